// File: rtl/operand_forward_if.sv
// Decode-to-forwarding-control bundle: decode-stage instruction fields and
// pipeline controls in, registered execute-stage mux selects and stall out.
interface operand_forward_if #(
  parameter int REG_ADDR_WIDTH = 5
) ();
  logic                      pipe_stall;
  logic                      flush;
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic                      id_rs1_use;
  logic                      id_rs2_use;
  logic                      id_op1_pc;
  logic                      id_op2_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic                      id_rd_write;
  logic                      id_is_load;
  logic [2:0]                ex_select1;
  logic [2:0]                ex_select2;
  logic                      load_use_stall;

  modport master (
    output pipe_stall, flush, id_valid, id_rs1_addr, id_rs2_addr, id_rs1_use,
           id_rs2_use, id_op1_pc, id_op2_imm, id_rd_addr, id_rd_write, id_is_load,
    input  ex_select1, ex_select2, load_use_stall
  );

  modport slave (
    input  pipe_stall, flush, id_valid, id_rs1_addr, id_rs2_addr, id_rs1_use,
           id_rs2_use, id_op1_pc, id_op2_imm, id_rd_addr, id_rd_write, id_is_load,
    output ex_select1, ex_select2, load_use_stall
  );
endinterface

// File: rtl/operand_forward_ctrl.sv
// Operand forwarding and load-use hazard control: tracks destination tags of
// the EX/MEM/WB instructions and registers the two execute-stage mux selects.
module operand_forward_ctrl #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic              clk,
  input logic              rst,
  operand_forward_if.slave fwd
);

  typedef enum logic [2:0] {
    SEL_REG   = 3'b000,
    SEL_EXMEM = 3'b001,
    SEL_MEMWB = 3'b010,
    SEL_WBBUF = 3'b011,
    SEL_PC    = 3'b100,
    SEL_IMM   = 3'b101
  } sel_e;

  typedef struct packed {
    logic                      valid;
    logic                      rd_write;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } tag_t;

  tag_t t_ex, t_mem, t_wb;
  logic ex_is_load;   // only the EX-stage load flag can cause a stall
  sel_e sel1_q, sel2_q, sel1_d, sel2_d;
  logic stall, bubble, rs1_live, rs2_live;

  function automatic logic hit(tag_t t, logic [REG_ADDR_WIDTH-1:0] rs);
    return t.valid && t.rd_write && (t.rd == rs) && (rs != '0);
  endfunction

  // Youngest producer first so the newest value of a register wins.
  function automatic sel_e fwd_code(tag_t ex, tag_t mem, tag_t wb,
                                    logic [REG_ADDR_WIDTH-1:0] rs);
    if (hit(ex, rs))       return SEL_EXMEM;
    else if (hit(mem, rs)) return SEL_MEMWB;
    else if (hit(wb, rs))  return SEL_WBBUF;
    else                   return SEL_REG;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    sel1_d   = SEL_REG;
    sel2_d   = SEL_REG;
    rs1_live = fwd.id_rs1_use && !fwd.id_op1_pc;
    rs2_live = fwd.id_rs2_use && !fwd.id_op2_imm;
    stall    = fwd.id_valid && !fwd.flush && t_ex.valid && ex_is_load &&
               ((rs1_live && hit(t_ex, fwd.id_rs1_addr)) ||
                (rs2_live && hit(t_ex, fwd.id_rs2_addr)));
    bubble   = stall || fwd.flush || !fwd.id_valid;
    if (!bubble) begin
      if (fwd.id_op1_pc)
        sel1_d = SEL_PC;
      else if (fwd.id_rs1_use)
        sel1_d = fwd_code(t_ex, t_mem, t_wb, fwd.id_rs1_addr);
      if (fwd.id_op2_imm)
        sel2_d = SEL_IMM;
      else if (fwd.id_rs2_use)
        sel2_d = fwd_code(t_ex, t_mem, t_wb, fwd.id_rs2_addr);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_ex       <= '0;
      t_mem      <= '0;
      t_wb       <= '0;
      ex_is_load <= 1'b0;
      sel1_q     <= SEL_REG;
      sel2_q     <= SEL_REG;
    end else if (!fwd.pipe_stall) begin
      t_wb   <= t_mem;
      t_mem  <= t_ex;
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
      if (bubble) begin
        t_ex       <= '0;
        ex_is_load <= 1'b0;
      end else begin
        t_ex       <= '{valid: 1'b1, rd_write: fwd.id_rd_write, rd: fwd.id_rd_addr};
        ex_is_load <= fwd.id_is_load;
      end
    end
  end

  assign fwd.ex_select1     = sel1_q;
  assign fwd.ex_select2     = sel2_q;
  assign fwd.load_use_stall = stall;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Bench for operand_forward_ctrl: directed vector table, reset-mid-stall
// sequence, then random instruction streams against an in-flight history model.
module tb_operand_forward_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  operand_forward_if #(.REG_ADDR_WIDTH(5)) fwd ();
  operand_forward_ctrl #(.REG_ADDR_WIDTH(5)) dut (.clk(clk), .rst(rst), .fwd(fwd));

  typedef struct {
    logic       valid;
    logic [4:0] rs1, rs2;
    logic       use1, use2, op1_pc, op2_imm;
    logic [4:0] rd;
    logic       rd_write, is_load, flush, pstall;
  } in_t;

  typedef struct {
    in_t        in;
    logic       exp_stall;
    logic [2:0] exp_s1, exp_s2;
  } vec_t;

  // One in-flight instruction as seen by the model; index 0 is the newest.
  typedef struct {
    logic       valid;
    logic       rd_write;
    logic [4:0] rd;
    logic       is_load;
  } ins_t;

  ins_t       hist [3];
  logic [2:0] m_s1, m_s2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t ins(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic pc, logic imm, logic [4:0] rd, logic rdw, logic ld,
                              logic fl, logic ps);
    in_t r;
    r.valid = v; r.rs1 = rs1; r.rs2 = rs2; r.use1 = u1; r.use2 = u2;
    r.op1_pc = pc; r.op2_imm = imm; r.rd = rd; r.rd_write = rdw; r.is_load = ld;
    r.flush = fl; r.pstall = ps;
    return r;
  endfunction

  function automatic vec_t vec(in_t i, logic st, logic [2:0] s1, logic [2:0] s2);
    vec_t r;
    r.in = i; r.exp_stall = st; r.exp_s1 = s1; r.exp_s2 = s2;
    return r;
  endfunction

  task automatic drive(input in_t i);
    fwd.id_valid    = i.valid;
    fwd.id_rs1_addr = i.rs1;
    fwd.id_rs2_addr = i.rs2;
    fwd.id_rs1_use  = i.use1;
    fwd.id_rs2_use  = i.use2;
    fwd.id_op1_pc   = i.op1_pc;
    fwd.id_op2_imm  = i.op2_imm;
    fwd.id_rd_addr  = i.rd;
    fwd.id_rd_write = i.rd_write;
    fwd.id_is_load  = i.is_load;
    fwd.flush       = i.flush;
    fwd.pipe_stall  = i.pstall;
  endtask

  // Distance (1..3 stages back) of the newest in-flight writer of rs, 0 if none.
  function automatic int producer_dist(logic [4:0] rs);
    if (rs == 5'd0) return 0;
    for (int d = 0; d < 3; d++)
      if (hist[d].valid && hist[d].rd_write && hist[d].rd == rs) return d + 1;
    return 0;
  endfunction

  function automatic logic model_stall(in_t i);
    logic hazard1, hazard2;
    hazard1 = i.use1 && !i.op1_pc  && producer_dist(i.rs1) == 1;
    hazard2 = i.use2 && !i.op2_imm && producer_dist(i.rs2) == 1;
    return i.valid && !i.flush && hist[0].is_load && (hazard1 || hazard2);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) hist[d] = '{1'b0, 1'b0, 5'd0, 1'b0};
    m_s1 = 3'd0;
    m_s2 = 3'd0;
  endtask

  task automatic model_advance(input in_t i);
    logic bub;
    if (i.pstall) return;
    bub  = !i.valid || i.flush || model_stall(i);
    m_s1 = bub ? 3'd0 : i.op1_pc  ? 3'd4 : !i.use1 ? 3'd0 : 3'(producer_dist(i.rs1));
    m_s2 = bub ? 3'd0 : i.op2_imm ? 3'd5 : !i.use2 ? 3'd0 : 3'(producer_dist(i.rs2));
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = bub ? '{1'b0, 1'b0, 5'd0, 1'b0} : '{1'b1, i.rd_write, i.rd, i.is_load};
  endtask

  vec_t tbl [23];
  in_t  idle, cur;

  initial begin
    idle = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //                 v  rs1 rs2 u1 u2 pc im rd rdw ld fl ps      stall s1 s2
    tbl[0]  = vec(ins(1,  1,  2, 1, 1, 0, 0,  5, 1, 0, 0, 0), 0, 3'd0, 3'd0);
    tbl[1]  = vec(ins(1,  5,  7, 1, 1, 0, 0,  6, 1, 0, 0, 0), 0, 3'd1, 3'd0);
    tbl[2]  = vec(ins(1,  0,  0, 1, 1, 0, 0,  5, 1, 0, 0, 0), 0, 3'd0, 3'd0);
    tbl[3]  = vec(ins(1,  5, 10, 1, 1, 0, 0,  9, 1, 0, 0, 0), 0, 3'd1, 3'd0);
    tbl[4]  = vec(ins(0,  9,  5, 1, 1, 0, 0,  3, 1, 0, 0, 0), 0, 3'd0, 3'd0);
    tbl[5]  = vec(ins(1,  9,  5, 1, 1, 0, 0, 11, 1, 0, 0, 0), 0, 3'd2, 3'd3);
    tbl[6]  = vec(ins(1,  0,  0, 1, 0, 0, 1, 12, 1, 1, 0, 0), 0, 3'd0, 3'd5);
    tbl[7]  = vec(ins(1, 12, 12, 1, 1, 0, 0, 13, 1, 0, 0, 0), 1, 3'd0, 3'd0);
    tbl[8]  = vec(ins(1, 12, 12, 1, 1, 0, 0, 13, 1, 0, 0, 0), 0, 3'd2, 3'd2);
    tbl[9]  = vec(ins(1, 13,  0, 1, 0, 0, 1,  5, 1, 1, 0, 0), 0, 3'd1, 3'd5);
    tbl[10] = vec(ins(1,  8,  5, 1, 1, 0, 1,  0, 0, 0, 0, 0), 0, 3'd0, 3'd5);
    tbl[11] = vec(ins(1,  0,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0), 0, 3'd0, 3'd0);
    tbl[12] = vec(ins(1,  0,  0, 1, 1, 0, 0, 14, 1, 0, 0, 0), 0, 3'd0, 3'd0);
    tbl[13] = vec(ins(1,  0,  0, 1, 0, 0, 1, 15, 1, 1, 0, 0), 0, 3'd0, 3'd5);
    tbl[14] = vec(ins(1, 15, 14, 1, 1, 0, 0, 16, 1, 0, 1, 0), 0, 3'd0, 3'd0);
    tbl[15] = vec(ins(1, 15, 14, 1, 1, 0, 0, 16, 1, 0, 0, 0), 0, 3'd2, 3'd3);
    tbl[16] = vec(ins(1, 16,  0, 1, 0, 0, 1, 17, 1, 1, 0, 0), 0, 3'd1, 3'd5);
    tbl[17] = vec(ins(1, 17, 16, 1, 1, 0, 0, 18, 1, 0, 0, 1), 1, 3'd1, 3'd5);
    tbl[18] = vec(ins(1, 17, 16, 1, 1, 0, 0, 18, 1, 0, 0, 1), 1, 3'd1, 3'd5);
    tbl[19] = vec(ins(1, 17, 16, 1, 1, 0, 0, 18, 1, 0, 0, 1), 1, 3'd1, 3'd5);
    tbl[20] = vec(ins(1, 17, 16, 1, 1, 0, 0, 18, 1, 0, 0, 0), 1, 3'd0, 3'd0);
    tbl[21] = vec(ins(1, 17, 16, 1, 1, 0, 0, 18, 1, 0, 0, 0), 0, 3'd2, 3'd3);
    tbl[22] = vec(ins(1,  3,  3, 0, 0, 1, 1, 19, 1, 0, 0, 0), 0, 3'd4, 3'd5);

    // Reset held two cycles.
    rst = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    check("reset_sel1", 32'(fwd.ex_select1), 32'd0);
    check("reset_sel2", 32'(fwd.ex_select2), 32'd0);
    check("reset_stall", 32'(fwd.load_use_stall), 32'd0);
    rst = 1'b0;

    for (int n = 0; n < 23; n++) begin
      drive(tbl[n].in);
      #1;
      check($sformatf("vec%0d_stall", n), 32'(fwd.load_use_stall), 32'(tbl[n].exp_stall));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_sel1", n), 32'(fwd.ex_select1), 32'(tbl[n].exp_s1));
      check($sformatf("vec%0d_sel2", n), 32'(fwd.ex_select2), 32'(tbl[n].exp_s2));
    end

    // Reset asserted while a load-use stall is pending clears everything.
    drive(ins(1, 0, 0, 0, 0, 0, 0, 20, 1, 1, 0, 0));
    @(posedge clk); #1;
    drive(ins(1, 20, 20, 1, 1, 0, 0, 21, 1, 0, 0, 0));
    #1;
    check("midstall_pending", 32'(fwd.load_use_stall), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midstall_reset_stall", 32'(fwd.load_use_stall), 32'd0);
    check("midstall_reset_sel1", 32'(fwd.ex_select1), 32'd0);
    @(posedge clk); #1;
    check("post_reset_sel1", 32'(fwd.ex_select1), 32'd0);

    // Random streams against the history model, starting from reset.
    rst = 1'b1;
    drive(idle);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    for (int n = 0; n < 2000; n++) begin
      cur = ins($urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      drive(cur);
      #1;
      check("rand_stall", 32'(fwd.load_use_stall), 32'(model_stall(cur)));
      model_advance(cur);
      @(posedge clk); #1;
      check("rand_sel1", 32'(fwd.ex_select1), 32'(m_s1));
      check("rand_sel2", 32'(fwd.ex_select2), 32'(m_s2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
